// File: rtl/stream_arb_mux_if.sv
// stream_arb_mux_if: N producer streams in (data/valid/last, ready back) and one registered consumer stream out (data/last/chan/valid, ready in); slave = mux side, master = producer/consumer side
interface stream_arb_mux_if #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W = $clog2(CHANNELS)
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0] in_valid;
  logic [CHANNELS-1:0] in_last;
  logic [CHANNELS-1:0] in_ready;
  logic [WIDTH-1:0] out_data;
  logic out_last;
  logic [SEL_W-1:0] out_chan;
  logic out_valid;
  logic out_ready;
  modport slave (
    input in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_chan, out_valid
  );
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input in_ready, out_data, out_last, out_chan, out_valid
  );
endinterface

// File: rtl/stream_arb_mux.sv
// stream_arb_mux: packet-locking round-robin/fixed-priority N:1 stream mux with registered output (ports: clk, reset_n sync active-low, s = slave stream bus)
module stream_arb_mux #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W = $clog2(CHANNELS),
  parameter int MODE = 0
) (
  input logic clk,
  input logic reset_n,
  stream_arb_mux_if.slave s
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, lock, lock_n, grant;
  logic grant_valid, accept, xfer;
  function automatic int pick_idx(input int k, input int base);
    int x;
    x = base + k;
    return MODE != 0 ? k : (x >= CHANNELS ? x - CHANNELS : x);
  endfunction
  always_comb begin
    grant = '0;
    grant_valid = 1'b0;
    if (state == LOCKED) begin
      grant = lock;
      grant_valid = 1'b1;
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (s.in_valid[pick_idx(k, int'(ptr))]) begin
          grant = SEL_W'(pick_idx(k, int'(ptr)));
          grant_valid = 1'b1;
        end
      end
    end
    accept = !s.out_valid || s.out_ready;
    s.in_ready = (reset_n && accept && grant_valid) ? CHANNELS'(1) << grant : '0;
    xfer = reset_n && accept && grant_valid && s.in_valid[grant];
    state_n = state;
    ptr_n = ptr;
    lock_n = lock;
    if (xfer) begin
      state_n = s.in_last[grant] ? IDLE : LOCKED;
      ptr_n = s.in_last[grant] ? (grant == SEL_W'(CHANNELS - 1) ? '0 : grant + 1'b1) : ptr;
      lock_n = s.in_last[grant] ? lock : grant;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      lock <= '0;
      s.out_valid <= 1'b0;
      s.out_data <= '0;
      s.out_last <= 1'b0;
      s.out_chan <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      lock <= lock_n;
      if (xfer) begin
        s.out_data <= s.in_data[int'(grant)*WIDTH +: WIDTH];
        s.out_last <= s.in_last[grant];
        s.out_chan <= grant;
        s.out_valid <= 1'b1;
      end else if (s.out_ready) begin
        s.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_arb_mux.sv
// tb_stream_arb_mux: directed and random checks of round-robin (u0) and fixed-priority (u1) muxes against a packet-level model
module tb_stream_arb_mux;
  localparam int W = 16;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic out_ready = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_last = '0;
  int vectors = 0;
  int errors = 0;
  bit armed = 1'b0;
  bit m_locked [2];
  int m_lock [2];
  int m_ptr [2];
  bit m_ov [2];
  bit m_ol [2];
  logic [W-1:0] m_od [2];
  int m_oc [2];
  always #5 clk = ~clk;
  stream_arb_mux_if #(.WIDTH(W), .CHANNELS(N)) if0 ();
  stream_arb_mux_if #(.WIDTH(W), .CHANNELS(N)) if1 ();
  assign if0.in_data = in_data;
  assign if0.in_valid = in_valid;
  assign if0.in_last = in_last;
  assign if0.out_ready = out_ready;
  assign if1.in_data = in_data;
  assign if1.in_valid = in_valid;
  assign if1.in_last = in_last;
  assign if1.out_ready = out_ready;
  stream_arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(0)) u0 (.clk(clk), .reset_n(reset_n), .s(if0.slave));
  stream_arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(1)) u1 (.clk(clk), .reset_n(reset_n), .s(if1.slave));
  function automatic int pick(input logic [N-1:0] v, input int ptr, input int mode);
    for (int k = 0; k < N; k++) begin
      int c;
      c = mode != 0 ? k : (ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction
  function automatic int exp_grant(input int d);
    return m_locked[d] ? m_lock[d] : pick(in_valid, m_ptr[d], d);
  endfunction
  function automatic logic [N-1:0] exp_ready(input int d);
    int g;
    g = exp_grant(d);
    if (!reset_n || g < 0 || !(!m_ov[d] || out_ready)) return '0;
    return N'(1) << g;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cmp(input int d, input logic [N-1:0] rdy, input logic ov, input logic [W-1:0] od, input logic ol, input logic [1:0] oc);
    chk($sformatf("u%0d in_ready", d), rdy, exp_ready(d));
    chk($sformatf("u%0d out_valid", d), ov, m_ov[d]);
    chk($sformatf("u%0d out_data", d), od, m_od[d]);
    chk($sformatf("u%0d out_last", d), ol, m_ol[d]);
    chk($sformatf("u%0d out_chan", d), oc, m_oc[d]);
  endtask
  always @(posedge clk) begin
    if (!reset_n) begin
      armed <= 1'b1;
      for (int d = 0; d < 2; d++) begin
        m_locked[d] <= 1'b0;
        m_lock[d] <= 0;
        m_ptr[d] <= 0;
        m_ov[d] <= 1'b0;
        m_ol[d] <= 1'b0;
        m_od[d] <= '0;
        m_oc[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (exp_ready(d) != '0 && in_valid[exp_grant(d)]) begin
          m_ov[d] <= 1'b1;
          m_od[d] <= in_data[exp_grant(d)*W +: W];
          m_ol[d] <= in_last[exp_grant(d)];
          m_oc[d] <= exp_grant(d);
          m_locked[d] <= !in_last[exp_grant(d)];
          if (in_last[exp_grant(d)]) m_ptr[d] <= (exp_grant(d) + 1) % N;
          else m_lock[d] <= exp_grant(d);
        end else if (out_ready) begin
          m_ov[d] <= 1'b0;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      cmp(0, if0.in_ready, if0.out_valid, if0.out_data, if0.out_last, if0.out_chan);
      cmp(1, if1.in_ready, if1.out_valid, if1.out_data, if1.out_last, if1.out_chan);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic setd(input int c, input logic [W-1:0] v);
    in_data[c*W +: W] = v;
  endtask
  initial begin
    chk("pick_rr_wrap", pick(4'b1001, 1, 0), 3);
    chk("pick_rr_at_ptr", pick(4'b0100, 2, 0), 2);
    chk("pick_fp_lowest", pick(4'b1010, 3, 1), 1);
    chk("pick_none", pick(4'b0000, 0, 0), 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", if0.out_valid, 0);
    chk("rst_data", if0.out_data, 16'h0000);
    chk("rst_chan", if0.out_chan, 0);
    chk("rst_ready", if0.in_ready, 4'b0000);
    step();
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_valid", if0.out_valid, 0);
      chk("idle_ready", if0.in_ready, 4'b0000);
    end
    step();
    in_valid = 4'hF;
    in_last = 4'hF;
    for (int c = 0; c < N; c++) setd(c, W'(16'h1000 + c));
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      chk("rr_chan", if0.out_chan, k % 4);
      chk("rr_data", if0.out_data, 16'h1000 + k % 4);
      chk("rr_valid", if0.out_valid, 1);
    end
    step();
    in_valid = '0;
    step();
    in_valid = 4'b0100;
    in_last = '0;
    setd(2, 16'h00A0);
    step();
    in_valid = 4'b0101;
    setd(2, 16'h00A1);
    setd(0, 16'h00B0);
    in_last = 4'b0001;
    @(negedge clk);
    chk("lock_chan0", if0.out_chan, 2);
    chk("lock_data0", if0.out_data, 16'h00A0);
    chk("lock_ready0", if0.in_ready, 4'b0100);
    step();
    setd(2, 16'h00A2);
    in_last = 4'b0101;
    @(negedge clk);
    chk("lock_chan1", if0.out_chan, 2);
    chk("lock_data1", if0.out_data, 16'h00A1);
    chk("lock_ready1", if0.in_ready, 4'b0100);
    step();
    in_valid = 4'b0001;
    @(negedge clk);
    chk("lock_data2", if0.out_data, 16'h00A2);
    chk("lock_last2", if0.out_last, 1);
    chk("lock_ready2", if0.in_ready, 4'b0001);
    step();
    in_valid = '0;
    @(negedge clk);
    chk("lock_next_chan", if0.out_chan, 0);
    chk("lock_next_data", if0.out_data, 16'h00B0);
    step();
    @(negedge clk);
    chk("drain_valid", if0.out_valid, 0);
    chk("drain_data_kept", if0.out_data, 16'h00B0);
    step();
    in_valid = 4'b0010;
    in_last = 4'b0010;
    setd(1, 16'h5555);
    step();
    in_valid = 4'b0001;
    in_last = 4'b0001;
    setd(0, 16'h1234);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_data", if0.out_data, 16'h5555);
      chk("bp_valid", if0.out_valid, 1);
      chk("bp_ready", if0.in_ready, 4'b0000);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", if0.in_ready, 4'b0001);
    step();
    in_valid = '0;
    @(negedge clk);
    chk("bp_next_data", if0.out_data, 16'h1234);
    chk("bp_next_chan", if0.out_chan, 0);
    step();
    in_valid = 4'b1010;
    in_last = 4'b1010;
    setd(1, 16'h0011);
    setd(3, 16'h0033);
    repeat (4) begin
      step();
      @(negedge clk);
      chk("fp_chan", if1.out_chan, 1);
      chk("fp_data", if1.out_data, 16'h0011);
      chk("fp_ready", if1.in_ready, 4'b0010);
    end
    step();
    in_valid = 4'b1000;
    @(negedge clk);
    chk("fp_ready3", if1.in_ready, 4'b1000);
    step();
    in_valid = '0;
    @(negedge clk);
    chk("fp_chan3", if1.out_chan, 3);
    chk("fp_data3", if1.out_data, 16'h0033);
    step();
    in_valid = 4'b0010;
    in_last = '0;
    setd(1, 16'h00C0);
    step();
    in_valid = 4'b0011;
    setd(1, 16'h00C1);
    setd(0, 16'h00D0);
    in_last = 4'b0001;
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_chan", if0.out_chan, 1);
    chk("mid_data", if0.out_data, 16'h00C0);
    chk("mid_rst_ready", if0.in_ready, 4'b0000);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_valid", if0.out_valid, 0);
    chk("mid_ready", if0.in_ready, 4'b0001);
    step();
    in_valid = '0;
    @(negedge clk);
    chk("mid_first_chan", if0.out_chan, 0);
    chk("mid_first_data", if0.out_data, 16'h00D0);
    for (int i = 0; i < 3000; i++) begin
      step();
      in_valid = N'($urandom);
      in_last = N'($urandom);
      in_data = {$urandom, $urandom};
      out_ready = ($urandom % 4) != 0;
      reset_n = ($urandom % 64) != 0;
    end
    step();
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
